// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register.
// - MODE_* : 3-bit operation select encoding driven on MODE
// - state_t: burst controller state (ST_IDLE / ST_RUN)
// - is_burst_mode(): true for modes that may be repeated as a burst
package shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Only the shift/rotate family can be repeated; hold, load and clear
  // are idempotent or meaningless as a burst.
  function automatic logic is_burst_mode(input logic [2:0] mode);
    return (mode >= MODE_SHL) && (mode <= MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_step_unit.sv
// Combinational next-value function for one step of the shift register.
// Ports:
//   q           in  WIDTH  current register contents
//   mode        in  3      operation (shift_pkg MODE_* encoding)
//   sin_l       in  1      serial bit entering the MSB on SHR
//   sin_r       in  1      serial bit entering the LSB on SHL
//   d           in  WIDTH  parallel load data
//   reset_value in  WIDTH  value used by the synchronous clear mode
//   q_next      out WIDTH  register contents after one step
module shift_step_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] reset_value,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      MODE_HOLD: q_next = q;
      MODE_LOAD: q_next = d;
      MODE_SHL:  q_next = {q[WIDTH-2:0], sin_r};
      MODE_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_CLR:  q_next = reset_value;
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with selectable clock edge, async clear, clock
// enable, parallel load, single-step shift/rotate and a counted burst mode.
// Ports:
//   CLK     in   clock; active edge chosen by NEG_EDGE (1 = falling)
//   CLR     in   asynchronous active-high clear
//   EN      in   clock enable; low freezes Q, count and state
//   MODE    in   operation select (shift_pkg MODE_*)
//   D       in   parallel load data
//   SIN_L   in   serial input into the MSB on right shifts
//   SIN_R   in   serial input into the LSB on left shifts
//   START   in   request a burst of AMT steps in the current MODE
//   AMT     in   burst length 0..WIDTH
//   Q       out  register contents
//   SOUT_L  out  Q[WIDTH-1]
//   SOUT_R  out  Q[0]
//   BUSY    out  burst in progress (registered)
//   DONE    out  one-edge pulse after the final burst step
//   state_dbg out burst controller state, for observation only
//
// Burst handshake: START is a request accepted only on an enabled active
// edge while BUSY is low and MODE is a shift/rotate mode. Once accepted,
// BUSY is high while steps remain; requests seen with BUSY high are dropped,
// not queued. Completion is signalled by DONE for exactly one edge period.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               NEG_EDGE    = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter int               AW          = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN_L,
  input  logic             SIN_R,
  input  logic             START,
  input  logic [AW-1:0]    AMT,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT_L,
  output logic             SOUT_R,
  output logic             BUSY,
  output logic             DONE,
  output state_t           state_dbg
);

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_r, q_n, step_q;
  logic [2:0]       mode_r, mode_n, step_mode;
  logic [AW-1:0]    cnt_r, cnt_n, amt_m1;
  state_t           st_r, st_n;
  logic             done_r, done_n;
  logic             start_ok;

  // In RUN the latched mode drives the step; otherwise the live MODE.
  assign step_mode = (st_r == ST_RUN) ? mode_r : MODE;
  assign start_ok  = (st_r == ST_IDLE) && START && is_burst_mode(MODE);
  assign amt_m1    = AMT - ONE;

  shift_step_unit #(
    .WIDTH (WIDTH)
  ) u_step (
    .q           (q_r),
    .mode        (step_mode),
    .sin_l       (SIN_L),
    .sin_r       (SIN_R),
    .d           (D),
    .reset_value (RESET_VALUE),
    .q_next      (step_q)
  );

  // Next-state logic. DONE defaults low so it is cleared on every active
  // edge, enabled or not, which keeps it to a single edge period.
  always_comb begin
    q_n    = q_r;
    mode_n = mode_r;
    cnt_n  = cnt_r;
    st_n   = st_r;
    done_n = 1'b0;
    if (EN) begin
      case (st_r)
        ST_IDLE: begin
          if (start_ok) begin
            mode_n = MODE;
            if (AMT == '0) begin
              // Zero-length burst: nothing to do, report completion.
              done_n = 1'b1;
            end else begin
              q_n   = step_q;
              cnt_n = amt_m1;
              if (amt_m1 != '0) st_n = ST_RUN;
              else              done_n = 1'b1;
            end
          end else begin
            q_n = step_q;
          end
        end
        ST_RUN: begin
          q_n   = step_q;
          cnt_n = cnt_r - ONE;
          if (cnt_r == ONE) begin
            st_n   = ST_IDLE;
            done_n = 1'b1;
          end
        end
        default: st_n = ST_IDLE;
      endcase
    end
  end

  // One register process; the generate branch only selects the clock edge.
  generate
    if (NEG_EDGE != 0) begin : g_neg
      always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
          q_r    <= RESET_VALUE;
          mode_r <= MODE_HOLD;
          cnt_r  <= '0;
          st_r   <= ST_IDLE;
          done_r <= 1'b0;
        end else begin
          q_r    <= q_n;
          mode_r <= mode_n;
          cnt_r  <= cnt_n;
          st_r   <= st_n;
          done_r <= done_n;
        end
      end
    end else begin : g_pos
      always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
          q_r    <= RESET_VALUE;
          mode_r <= MODE_HOLD;
          cnt_r  <= '0;
          st_r   <= ST_IDLE;
          done_r <= 1'b0;
        end else begin
          q_r    <= q_n;
          mode_r <= mode_n;
          cnt_r  <= cnt_n;
          st_r   <= st_n;
          done_r <= done_n;
        end
      end
    end
  endgenerate

  assign Q         = q_r;
  assign SOUT_L    = q_r[WIDTH-1];
  assign SOUT_R    = q_r[0];
  assign BUSY      = (st_r == ST_RUN);
  assign DONE      = done_r;
  assign state_dbg = st_r;

endmodule
